// File: rtl/hs_tx_multilane.sv
// Multi-lane D-PHY HS transmit burst sequencer: HS-ZERO, SYNC, payload, HS-TRAIL, EXIT.
// Each lane serialises one byte per 4-cycle slot, two bits per DDR clock cycle, LSB first.
module hs_tx_multilane #(
    parameter int          LANES       = 2,
    parameter int          ZERO_BYTES  = 4,
    parameter int          TRAIL_BYTES = 2,
    parameter logic [7:0]  SYNC_BYTE   = 8'hB8
) (
    input  logic                 TxDDRClk,
    input  logic                 TxRst,
    input  logic                 TxRequestHS,
    input  logic [8*LANES-1:0]   TxDataHS,
    input  logic                 TxValidHS,
    output logic                 TxReadyHS,
    output logic [2*LANES-1:0]   HS_Bits,
    output logic                 HS_En,
    output logic [2:0]           DphyTxState,
    output logic                 TxUnderflow,
    output logic [15:0]          BurstBytes
);

    localparam int MAX_SLOTS = (ZERO_BYTES > TRAIL_BYTES) ? ZERO_BYTES : TRAIL_BYTES;
    localparam int SLOT_W    = $clog2(MAX_SLOTS + 1);

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_ZERO  = 3'd1,
        ST_SYNC  = 3'd2,
        ST_DATA  = 3'd3,
        ST_TRAIL = 3'd4,
        ST_EXIT  = 3'd5
    } state_t;

    state_t                    state_q;
    logic [1:0]                phase_q;
    logic [SLOT_W-1:0]         slot_q;
    logic [LANES-1:0][7:0]     sr_q;
    logic                      hs_en_q;
    logic [15:0]               bytes_q;

    logic [LANES-1:0][7:0]     shift_d;
    logic [LANES-1:0][7:0]     trail_d;
    logic [LANES-1:0][7:0]     hold_d;
    logic [15:0]               bytes_d;
    logic                      slot_end;
    logic                      decide;
    logic                      accept;

    always_comb begin
        slot_end    = (state_q != ST_IDLE) && (phase_q == 2'd3);
        decide      = slot_end && ((state_q == ST_SYNC) || (state_q == ST_DATA));
        TxReadyHS   = decide && TxRequestHS;
        accept      = TxReadyHS && TxValidHS;
        TxUnderflow = TxReadyHS && !TxValidHS;
        bytes_d     = (bytes_q == 16'hFFFF) ? bytes_q : bytes_q + 16'd1;
        HS_Bits     = '0;
        for (int k = 0; k < LANES; k++) begin
            shift_d[k] = {2'b00, sr_q[k][7:2]};
            // At the phase-3 cycle sr[1] still holds bit 7 of the byte on the wire.
            trail_d[k] = (state_q == ST_SYNC) ? 8'h00 : {8{~sr_q[k][1]}};
            hold_d[k]  = {8{sr_q[k][0]}};
            HS_Bits[2*k +: 2] = sr_q[k][1:0];
        end
    end

    assign HS_En       = hs_en_q;
    assign DphyTxState = state_q;
    assign BurstBytes  = bytes_q;

    always_ff @(posedge TxDDRClk or negedge TxRst) begin
        if (!TxRst) begin
            state_q <= ST_IDLE;
            phase_q <= '0;
            slot_q  <= '0;
            sr_q    <= '0;
            hs_en_q <= 1'b0;
            bytes_q <= '0;
        end else if (state_q == ST_IDLE) begin
            phase_q <= '0;
            sr_q    <= '0;
            if (TxRequestHS) begin
                state_q <= ST_ZERO;
                slot_q  <= '0;
                bytes_q <= '0;
                hs_en_q <= 1'b1;
            end
        end else begin
            phase_q <= phase_q + 2'd1;
            sr_q    <= shift_d;
            if (slot_end) begin
                case (state_q)
                    ST_ZERO: begin
                        if (slot_q == SLOT_W'(ZERO_BYTES - 1)) begin
                            state_q <= ST_SYNC;
                            sr_q    <= {LANES{SYNC_BYTE}};
                        end else begin
                            slot_q <= slot_q + SLOT_W'(1);
                        end
                    end
                    ST_SYNC, ST_DATA: begin
                        if (accept) begin
                            state_q <= ST_DATA;
                            sr_q    <= TxDataHS;
                            bytes_q <= bytes_d;
                        end else begin
                            state_q <= ST_TRAIL;
                            slot_q  <= '0;
                            sr_q    <= trail_d;
                        end
                    end
                    ST_TRAIL: begin
                        if (slot_q == SLOT_W'(TRAIL_BYTES - 1)) begin
                            state_q <= ST_EXIT;
                            hs_en_q <= 1'b0;
                            sr_q    <= '0;
                        end else begin
                            slot_q <= slot_q + SLOT_W'(1);
                            sr_q   <= hold_d;
                        end
                    end
                    default: state_q <= ST_IDLE;
                endcase
            end
        end
    end

endmodule
